// File: rtl/agc_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : agc_gain_ctrl
// Description : AGC loop closure on the complex_mult output stream. Measures
//               mean |z|^2 over fixed windows of accepted samples, compares
//               against a target with a dead band and steps the real gain
//               coefficient fed back to complex_mult b_real.
// Revision    : 1.0 - initial release
// ============================================================================
module agc_gain_ctrl #(
    parameter int IN_WIDTH = 33,
    parameter int DWIDTH   = 16,
    parameter int BWIDTH   = 16,
    parameter int LOG2_WIN = 4,
    parameter logic [2*DWIDTH:0]        TARGET    = (2*DWIDTH+1)'(16777216),
    parameter logic [2*DWIDTH:0]        HYST      = (2*DWIDTH+1)'(1048576),
    parameter logic signed [BWIDTH-1:0] STEP      = BWIDTH'(64),
    parameter logic signed [BWIDTH-1:0] GAIN_INIT = BWIDTH'(16384),
    parameter logic signed [BWIDTH-1:0] GAIN_MIN  = BWIDTH'(256),
    parameter logic signed [BWIDTH-1:0] GAIN_MAX  = BWIDTH'(32767)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid,
    input  logic signed [IN_WIDTH-1:0] z_real,
    input  logic signed [IN_WIDTH-1:0] z_imag,
    input  logic                       freeze,
    output logic signed [BWIDTH-1:0]   gain,
    output logic                       gain_valid,
    output logic [2*DWIDTH:0]          pwr_mean,
    output logic [1:0]                 dir
);

    localparam int PW = 2*DWIDTH + 1;
    localparam int AW = PW + LOG2_WIN;

    // Dead-band edges, one bit wider so TARGET+HYST cannot wrap.
    localparam logic [PW:0] TH_LO = (TARGET > HYST) ? ({1'b0, TARGET} - {1'b0, HYST}) : '0;
    localparam logic [PW:0] TH_HI = {1'b0, TARGET} + {1'b0, HYST};

    localparam logic signed [BWIDTH:0] MAX_X  = {GAIN_MAX[BWIDTH-1], GAIN_MAX};
    localparam logic signed [BWIDTH:0] MIN_X  = {GAIN_MIN[BWIDTH-1], GAIN_MIN};
    localparam logic signed [BWIDTH:0] STEP_X = {STEP[BWIDTH-1], STEP};

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DECIDE = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    // Only the top DWIDTH bits of each component feed the power estimate.
    logic unused_lsbs;
    assign unused_lsbs = ^{z_real[IN_WIDTH-DWIDTH-1:0], z_imag[IN_WIDTH-DWIDTH-1:0]};

    logic                       v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [DWIDTH-1:0]          zr0_q, zr0_d, zi0_q, zi0_d;
    logic [DWIDTH-1:0]          dr1_q, dr1_d, di1_q, di1_d;
    logic [PW-1:0]              p2_q, p2_d;
    logic [AW-1:0]              acc_q, acc_d;
    logic [LOG2_WIN-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]              pwr_mean_q, pwr_mean_d;
    logic [1:0]                 dir_q, dir_d;
    logic signed [BWIDTH-1:0]   gain_q, gain_d;
    logic                       gain_valid_q, gain_valid_d;
    state_t                     state_q, state_d;

    logic [2*DWIDTH-1:0]        dr_ext, di_ext, sq_r, sq_i;
    logic [AW-1:0]              acc_sum;
    logic                       win_done;
    logic signed [BWIDTH:0]     gain_x, gain_up, gain_dn;

    function automatic logic signed [BWIDTH-1:0] clamp_gain(input logic signed [BWIDTH:0] s);
        if (s > MAX_X)
            return GAIN_MAX;
        else if (s < MIN_X)
            return GAIN_MIN;
        else
            return s[BWIDTH-1:0];
    endfunction

    // Measurement pipeline: capture MSBs, square-and-sum, windowed accumulate.
    always_comb begin
        v0_d  = valid;
        zr0_d = z_real[IN_WIDTH-1 -: DWIDTH];
        zi0_d = z_imag[IN_WIDTH-1 -: DWIDTH];

        v1_d  = v0_q;
        dr1_d = zr0_q;
        di1_d = zi0_q;

        // Low 2*DWIDTH bits of the sign-extended product are exact: |d|^2 <= 2^(2*DWIDTH-2).
        dr_ext = {{DWIDTH{dr1_q[DWIDTH-1]}}, dr1_q};
        di_ext = {{DWIDTH{di1_q[DWIDTH-1]}}, di1_q};
        sq_r   = dr_ext * dr_ext;
        sq_i   = di_ext * di_ext;
        v2_d   = v1_q;
        p2_d   = {1'b0, sq_r} + {1'b0, sq_i};

        acc_sum    = acc_q + {{LOG2_WIN{1'b0}}, p2_q};
        win_done   = v2_q && (&cnt_q);
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        pwr_mean_d = pwr_mean_q;
        if (v2_q) begin
            if (&cnt_q) begin
                // Last sample of the window: publish mean and restart cleanly.
                acc_d      = '0;
                cnt_d      = '0;
                pwr_mean_d = acc_sum[AW-1:LOG2_WIN];
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + LOG2_WIN'(1);
            end
        end
    end

    // Decision FSM: classify the window mean, then step and clamp the gain.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        gain_d       = gain_q;
        gain_valid_d = 1'b0;
        gain_x       = {gain_q[BWIDTH-1], gain_q};
        gain_up      = gain_x + STEP_X;
        gain_dn      = gain_x - STEP_X;
        case (state_q)
            ST_ACCUM: begin
                if (win_done)
                    state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if ({1'b0, pwr_mean_q} < TH_LO)
                    dir_d = DIR_UP;
                else if ({1'b0, pwr_mean_q} > TH_HI)
                    dir_d = DIR_DOWN;
                else
                    dir_d = DIR_HOLD;
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                gain_valid_d = 1'b1;
                if (!freeze) begin
                    if (dir_q == DIR_UP)
                        gain_d = clamp_gain(gain_up);
                    else if (dir_q == DIR_DOWN)
                        gain_d = clamp_gain(gain_dn);
                end
                state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State registers; reset drops any partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            zr0_q        <= '0;
            zi0_q        <= '0;
            dr1_q        <= '0;
            di1_q        <= '0;
            p2_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            pwr_mean_q   <= '0;
            dir_q        <= DIR_HOLD;
            gain_q       <= GAIN_INIT;
            gain_valid_q <= 1'b0;
            state_q      <= ST_ACCUM;
        end else begin
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            zr0_q        <= zr0_d;
            zi0_q        <= zi0_d;
            dr1_q        <= dr1_d;
            di1_q        <= di1_d;
            p2_q         <= p2_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            pwr_mean_q   <= pwr_mean_d;
            dir_q        <= dir_d;
            gain_q       <= gain_d;
            gain_valid_q <= gain_valid_d;
            state_q      <= state_d;
        end
    end

    assign gain       = gain_q;
    assign gain_valid = gain_valid_q;
    assign pwr_mean   = pwr_mean_q;
    assign dir        = dir_q;

endmodule
`default_nettype wire
